// File: rtl/food_ctrl.sv
// Food placement and eat-detection controller for the LED-array snake game.
// Pulls candidates from the random box generator, vets them, arms food, scores eats.
module food_ctrl #(
  parameter int unsigned X_MAX   = 64,
  parameter int unsigned Y_MAX   = 32,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned MAX_TRY = 255,
  parameter int unsigned SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               head_valid,
  input  logic [6:0]         head_x,
  input  logic [4:0]         head_y,
  input  logic [6:0]         box_x,
  input  logic [4:0]         box_y,
  output logic               drive,
  output logic               occ_req,
  output logic [6:0]         occ_x,
  output logic [4:0]         occ_y,
  input  logic               occ_ack,
  input  logic               occ_hit,
  output logic [6:0]         food_x,
  output logic [4:0]         food_y,
  output logic               food_valid,
  output logic               eat,
  output logic [SCORE_W-1:0] score,
  output logic               full
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned RW = (MAX_TRY > 1) ? $clog2(MAX_TRY + 1) : 1;

  typedef enum logic [2:0] {REQ, WAIT, CHECK, QUERY, ARMED, FULL} state_t;

  state_t        state;
  logic [CW-1:0] settle;
  logic [RW-1:0] retry;
  logic          in_range;
  logic          last_try;

  // Compare at full int width so a limit equal to 2**coord_width still works.
  assign in_range = (32'(occ_x) < X_MAX) && (32'(occ_y) < Y_MAX);
  assign last_try = ((32'(retry) + 32'd1) >= MAX_TRY);

  // Placement / eat state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= REQ;
      settle     <= {CW{1'b0}};
      retry      <= {RW{1'b0}};
      drive      <= 1'b0;
      occ_req    <= 1'b0;
      occ_x      <= 7'd0;
      occ_y      <= 5'd0;
      food_x     <= 7'd0;
      food_y     <= 5'd0;
      food_valid <= 1'b0;
      eat        <= 1'b0;
      score      <= {SCORE_W{1'b0}};
      full       <= 1'b0;
    end else begin
      drive <= 1'b0;
      eat   <= 1'b0;
      case (state)
        REQ: begin
          drive  <= 1'b1;
          settle <= CW'(SETTLE - 1);
          state  <= WAIT;
        end
        WAIT: begin
          if (settle == {CW{1'b0}}) begin
            occ_x <= box_x;
            occ_y <= box_y;
            state <= CHECK;
          end else begin
            settle <= settle - CW'(1);
          end
        end
        CHECK: begin
          if (in_range) begin
            occ_req <= 1'b1;
            state   <= QUERY;
          end else begin
            retry <= retry + RW'(1);
            if (last_try) begin
              full  <= 1'b1;
              state <= FULL;
            end else begin
              state <= REQ;
            end
          end
        end
        QUERY: begin
          // occ_req stays up until the body store answers.
          if (occ_req && occ_ack) begin
            occ_req <= 1'b0;
            if (occ_hit) begin
              retry <= retry + RW'(1);
              if (last_try) begin
                full  <= 1'b1;
                state <= FULL;
              end else begin
                state <= REQ;
              end
            end else begin
              food_x     <= occ_x;
              food_y     <= occ_y;
              food_valid <= 1'b1;
              retry      <= {RW{1'b0}};
              state      <= ARMED;
            end
          end
        end
        ARMED: begin
          if (head_valid && (head_x == food_x) && (head_y == food_y)) begin
            eat        <= 1'b1;
            food_valid <= 1'b0;
            if (score != {SCORE_W{1'b1}}) begin
              score <= score + SCORE_W'(1);
            end
            state <= REQ;
          end
        end
        FULL: begin
          full       <= 1'b1;
          food_valid <= 1'b0;
        end
        default: begin
          state <= REQ;
        end
      endcase
    end
  end

endmodule
